// File: rtl/mux4to1_rr_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the four-way mux arbiter.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Circular search starting just after 'last'; bits set in 'mask' never win.
    // Walking from the farthest slot back to the nearest lets the nearest overwrite.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [SEL_W-1:0]   last,
                                      input logic [NUM_REQ-1:0] mask);
        pick_t            res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = last + SEL_W'(k);
            if (req[idx] && !mask[idx]) begin
                res.valid = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux4to1.sv
// Plain 4:1 single-bit multiplexer.
module mux4to1 (
    input  logic [3:0] x,
    input  logic [1:0] c,
    output logic       y
);

    assign y = x[c];

endmodule

// File: rtl/mux4to1_rr_arbiter.sv
// Round-robin arbiter with bounded hold time sharing one mux4to1 between four requesters.
module mux4to1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int NUM_REQ  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] data,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               y,
    output logic               y_vld
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    if (NUM_REQ != mux_arb_pkg::NUM_REQ) begin : g_bad_num_req
        $error("mux4to1_rr_arbiter: NUM_REQ must be 4");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux4to1_rr_arbiter: MAX_HOLD must be in 1..255");
    end

    state_t              state, state_next;
    logic [NUM_REQ-1:0]  gnt_next;
    logic [SEL_W-1:0]    sel_next;
    logic [SEL_W-1:0]    last_owner, last_owner_next;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_next;
    pick_t               pick_any, pick_excl;
    logic                mux_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= '0;
            sel        <= '0;
            last_owner <= SEL_W'(NUM_REQ - 1);
            hold_cnt   <= '0;
        end else begin
            state      <= state_next;
            gnt        <= gnt_next;
            sel        <= sel_next;
            last_owner <= last_owner_next;
            hold_cnt   <= hold_cnt_next;
        end
    end

    always_comb begin
        state_next      = state;
        gnt_next        = gnt;
        sel_next        = sel;
        last_owner_next = last_owner;
        hold_cnt_next   = hold_cnt;

        pick_any  = rr_pick(req, last_owner, '0);
        // Forced release must never hand the grant straight back to the owner.
        pick_excl = rr_pick(req, last_owner, gnt);

        case (state)
            IDLE: begin
                if (pick_any.valid) begin
                    state_next      = GRANT;
                    gnt_next        = NUM_REQ'(1) << pick_any.idx;
                    sel_next        = pick_any.idx;
                    last_owner_next = pick_any.idx;
                    hold_cnt_next   = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    if (pick_any.valid) begin
                        gnt_next        = NUM_REQ'(1) << pick_any.idx;
                        sel_next        = pick_any.idx;
                        last_owner_next = pick_any.idx;
                        hold_cnt_next   = HOLD_W'(1);
                    end else begin
                        state_next = IDLE;
                        gnt_next   = '0;
                    end
                end else if (hold_cnt == HOLD_MAX && pick_excl.valid) begin
                    gnt_next        = NUM_REQ'(1) << pick_excl.idx;
                    sel_next        = pick_excl.idx;
                    last_owner_next = pick_excl.idx;
                    hold_cnt_next   = HOLD_W'(1);
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_cnt_next = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    mux4to1 u_mux (
        .x (data),
        .c (sel),
        .y (mux_y)
    );

    assign y_vld = |gnt;
    assign y     = mux_y & y_vld;

endmodule

// File: tb/tb_mux4to1_rr_arbiter.sv
// Directed plus randomized checks of the round-robin arbiter against a behavioural model.
module tb_mux4to1_rr_arbiter;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] data = '0;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       y;
    logic       y_vld;

    int tests = 0;
    int failed = 0;

    // Model: owner index (-1 when idle), hold length, last winner, last driven select.
    int m_owner, m_hold, m_last, m_sel;

    mux4to1_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .NUM_REQ(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .data  (data),
        .gnt   (gnt),
        .sel   (sel),
        .y     (y),
        .y_vld (y_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int after, input int excl);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (after + k) % 4;
            if (r[idx] && idx != excl) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_hold = 0; m_last = 3; m_sel = 0;
    endtask

    task automatic model_take(input int p);
        m_owner = p; m_hold = 1; m_last = p; m_sel = p;
    endtask

    task automatic model_edge(input logic [3:0] r);
        int p;
        if (m_owner < 0) begin
            p = pick(r, m_last, -1);
            if (p >= 0) model_take(p);
        end else if (!r[m_owner]) begin
            p = pick(r, m_last, -1);
            if (p >= 0) model_take(p);
            else m_owner = -1;
        end else begin
            p = pick(r, m_last, m_owner);
            if (m_hold == MAX_HOLD && p >= 0) model_take(p);
            else if (m_hold < MAX_HOLD) m_hold++;
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] exp_gnt;
        exp_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        chk({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
        chk({tag, ".y_vld"}, 32'(y_vld), 32'(m_owner >= 0));
        chk({tag, ".y"}, 32'(y), (m_owner >= 0) ? 32'(data[m_owner]) : 32'd0);
        chk({tag, ".sel"}, 32'(sel), 32'(m_sel));
        chk({tag, ".onehot0"}, 32'($onehot0(gnt)), 32'd1);
    endtask

    // Called at a negedge: drive inputs, advance the model, check after the edge.
    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] d);
        req = r;
        data = d;
        model_edge(r);
        @(posedge clk);
        #1;
        check_all(tag);
        $display("[TB] %s req=%b data=%b gnt=%b sel=%0d y=%b y_vld=%b", tag, r, d, gnt, sel, y, y_vld);
        @(negedge clk);
    endtask

    task automatic do_reset();
        req = '0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] r;
        int         owners[$];
        int         idle_seen;

        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single requester grant and release.
        step("single", 4'b0001, 4'b0001);
        chk("single.gnt_lit", 32'(gnt), 32'h1);
        chk("single.y_lit", 32'(y), 32'h1);
        step("release", 4'b0000, 4'b0001);
        chk("release.gnt_lit", 32'(gnt), 32'h0);
        chk("release.y_lit", 32'(y), 32'h0);

        // Full contention: 0,1,2,3,0 with MAX_HOLD cycles each.
        do_reset();
        idle_seen = 0;
        for (int i = 0; i < 4 * MAX_HOLD + 1; i++) begin
            step("rr_all", 4'b1111, 4'($urandom_range(0, 15)));
            owners.push_back(int'(sel));
            if (!y_vld) idle_seen++;
        end
        for (int i = 0; i < 4 * MAX_HOLD + 1; i++)
            chk("rr_all.seq", 32'(owners[i]), 32'((i / MAX_HOLD) % 4));
        chk("rr_all.no_idle", 32'(idle_seen), 32'd0);

        // Long uncontended hold by 2, then contention forces a move to 1.
        do_reset();
        for (int i = 0; i < 20; i++) step("hold2", 4'b0100, 4'b0100);
        chk("hold2.hold_sat", 32'(m_hold), 32'(MAX_HOLD));
        step("hold2.contend", 4'b0110, 4'b0010);
        chk("hold2.moved_to_1", 32'(gnt), 32'b0010);

        // Back-to-back handover when owner drops as another rises.
        do_reset();
        step("b2b.own0", 4'b0001, 4'b1000);
        step("b2b.hand", 4'b1000, 4'b1000);
        chk("b2b.gnt_lit", 32'(gnt), 32'b1000);
        chk("b2b.sel_lit", 32'(sel), 32'd3);

        // Asynchronous reset between edges while granted to 2.
        do_reset();
        step("areset.own2", 4'b0100, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("areset.gnt", 32'(gnt), 32'h0);
        chk("areset.y_vld", 32'(y_vld), 32'h0);
        chk("areset.y", 32'(y), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step("areset.first", 4'b0101, 4'b0101);
        chk("areset.first_lit", 32'(gnt), 32'b0001);

        // Data routing with requesters 1 and 3.
        do_reset();
        for (int i = 0; i < 3 * MAX_HOLD; i++) begin
            step("data1010", 4'b1010, 4'b1010);
            chk("data1010.y_lit", 32'(y), 32'd1);
        end
        step("data1010.off", 4'b0000, 4'b1010);
        chk("data1010.off_y", 32'(y), 32'd0);

        // Randomized traffic; requests are often held to exercise the hold limit.
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            step("rand", r, 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
